// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions: frame geometry and deframer state encoding.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_if.sv
// Consumer-side bundle of the PS/2 receiver: FIFO head handshake, status pulses, occupancy.
interface ps2_rx_if #(
    parameter int FIFO_DEPTH = 4
);
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0]    out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        frame_err;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output out_data, out_valid, frame_err, overflow, fifo_count,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, frame_err, overflow, fifo_count,
        output out_ready
    );

endinterface

// File: rtl/ps2_fifo.sv
// Generic synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop from empty is ignored.
module ps2_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    // NOTE: the storage array is deliberately not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises kbd lines, deframes 11-bit frames (odd parity,
// stop=1) and queues good bytes in a FWFT FIFO.
// Optional build macro PS2_RX_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYCLES idle cycles.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] kbd,
    ps2_rx_if.master   bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0]   ps2c_sync_q, ps2c_sync_d;
    logic [SYNC_STAGES-1:0]   ps2d_sync_q, ps2d_sync_d;
    logic                     ps2c_prev_q, ps2c_prev_d;
    logic                     ps2c, ps2d, fall;

    ps2_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                     par_ok_q, par_ok_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overflow_q, overflow_d;
    logic                     push;

    logic                     fifo_full, fifo_empty, pop_hs;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
`endif

    assign ps2c = ps2c_sync_q[SYNC_STAGES-1];
    assign ps2d = ps2d_sync_q[SYNC_STAGES-1];
    assign fall = ps2c_prev_q & ~ps2c;

    // Shift chains for the raw lines plus the previous synced clock for edge detection.
    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[SYNC_STAGES-2:0], kbd[0]};
        ps2d_sync_d = {ps2d_sync_q[SYNC_STAGES-2:0], kbd[1]};
        ps2c_prev_d = ps2c;
    end

    // Deframer: advances only on a synced PS/2 clock falling edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_ok_d    = par_ok_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!ps2d) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shreg_d   = {ps2d, shreg_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shreg_q, ps2d};
                    state_d  = STOP;
                end
                STOP: begin
                    if (ps2d && par_ok_q) push = 1'b1;
                    else                  frame_err_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
    end

    assign pop_hs     = bus.out_ready & ~fifo_empty;
    assign overflow_d = push & fifo_full & ~pop_hs;

    // Synchroniser, deframer and status-pulse registers; sync flops idle high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_sync_q <= '1;
            ps2d_sync_q <= '1;
            ps2c_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            ps2c_prev_q <= ps2c_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    // Idle-time counter for aborting stalled frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    ps2_fifo #(
        .DATA_WIDTH (PS2_DATA_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shreg_q),
        .pop   (bus.out_ready),
        .dout  (bus.out_data),
        .count (bus.fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;

endmodule
